// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, fetches from a combinational
// instruction memory and fills the IF/ID register, with redirect, stall and fault handling.
module rv32i_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 1024,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        id_fault,
   output logic [1:0]  id_cause,
   output logic        fetch_halted
);

   localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        id_valid_q, id_valid_d;
   logic        id_fault_q, id_fault_d;
   logic [1:0]  id_cause_q, id_cause_d;
   logic        mis, oor;

   // Word index compared at full width so huge PCs never alias into range.
   assign mis = (pc_q[1:0] != 2'b00);
   assign oor = (pc_q[31:2] >= DEPTH_W);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      id_fault_d = id_fault_q;
      id_cause_d = id_cause_q;
      if (redirect_valid) begin
         pc_d       = redirect_target;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
         id_fault_d = 1'b0;
         id_cause_d = 2'b00;
         state_d    = RUN;
      end else if (!stall) begin
         case (state_q)
            RUN: begin
               id_pc_d    = pc_q;
               id_valid_d = 1'b1;
               if (mis || oor) begin
                  id_instr_d = NOP_INSTR;
                  id_fault_d = 1'b1;
                  id_cause_d = mis ? 2'b01 : 2'b10;
                  state_d    = FAULT;
               end else begin
                  id_instr_d = imem_instr;
                  id_fault_d = 1'b0;
                  id_cause_d = 2'b00;
                  pc_d       = pc_q + 32'd4;
               end
            end
            FAULT: begin
               // Fault report is single-shot; cause stays visible for debug.
               id_valid_d = 1'b0;
               id_fault_d = 1'b0;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         id_pc_q    <= 32'h0;
         id_instr_q <= NOP_INSTR;
         id_valid_q <= 1'b0;
         id_fault_q <= 1'b0;
         id_cause_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
         id_fault_q <= id_fault_d;
         id_cause_q <= id_cause_d;
      end
   end

   assign imem_addr    = pc_q;
   assign id_pc        = id_pc_q;
   assign id_instr     = id_instr_q;
   assign id_valid     = id_valid_q;
   assign id_fault     = id_fault_q;
   assign id_cause     = id_cause_q;
   assign fetch_halted = (state_q == FAULT);

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Drives two fetch stages (1024-word and 4-word memories) with the same directed and
// random stimulus and compares every output each cycle against a behavioural model.
module tb_rv32i_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, stall, rv;
   logic [31:0] tgt;

   logic [31:0] addr [2];
   logic [31:0] instr [2];
   logic [31:0] idpc [2];
   logic [31:0] idin [2];
   logic        idv [2];
   logic        idf [2];
   logic [1:0]  idc [2];
   logic        halt [2];

   int unsigned depth [2] = '{1024, 4};
   logic [31:0] base  [2] = '{32'h1000_0000, 32'h2000_0000};

   // Reference model state
   logic [31:0] m_pc [2], m_idpc [2], m_instr [2];
   logic        m_v [2], m_f [2], m_halt [2];
   logic [1:0]  m_c [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mword(input int d, input logic [31:0] a);
      return base[d] + ((a >> 2) % depth[d]);
   endfunction

   assign instr[0] = mword(0, addr[0]);
   assign instr[1] = mword(1, addr[1]);

   rv32i_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(1024), .NOP_INSTR(NOP)) dut0 (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr[0]), .imem_instr(instr[0]),
      .stall(stall), .redirect_valid(rv), .redirect_target(tgt),
      .id_pc(idpc[0]), .id_instr(idin[0]), .id_valid(idv[0]), .id_fault(idf[0]),
      .id_cause(idc[0]), .fetch_halted(halt[0]));

   rv32i_fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(4), .NOP_INSTR(NOP)) dut1 (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr[1]), .imem_instr(instr[1]),
      .stall(stall), .redirect_valid(rv), .redirect_target(tgt),
      .id_pc(idpc[1]), .id_instr(idin[1]), .id_valid(idv[1]), .id_fault(idf[1]),
      .id_cause(idc[1]), .fetch_halted(halt[1]));

   task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s dut%0d got=%h exp=%h", tag, d, got, exp);
      end
   endtask

   // Model advance for one edge, from the behavioural rules.
   task automatic model(input int d, input logic r, input logic s, input logic re, input logic [31:0] t);
      logic [1:0] code;
      if (r) begin
         m_pc[d] = 32'h0; m_idpc[d] = 32'h0; m_instr[d] = NOP;
         m_v[d] = 0; m_f[d] = 0; m_c[d] = 0; m_halt[d] = 0;
      end else if (re) begin
         m_pc[d] = t; m_instr[d] = NOP; m_v[d] = 0; m_f[d] = 0; m_c[d] = 0; m_halt[d] = 0;
      end else if (s) begin
      end else if (m_halt[d]) begin
         m_v[d] = 0; m_f[d] = 0;
      end else begin
         if (m_pc[d] % 4 != 0)                        code = 2'b01;
         else if ((m_pc[d] / 4) >= 32'(depth[d]))     code = 2'b10;
         else                                         code = 2'b00;
         m_idpc[d] = m_pc[d];
         m_v[d]    = 1;
         m_c[d]    = code;
         if (code != 0) begin
            m_instr[d] = NOP; m_f[d] = 1; m_halt[d] = 1;
         end else begin
            m_instr[d] = base[d] + m_pc[d] / 4; m_f[d] = 0; m_pc[d] = m_pc[d] + 32'd4;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic re, input logic [31:0] t);
      rst_n = ~r; stall = s; rv = re; tgt = t;
      for (int d = 0; d < 2; d++) model(d, r, s, re, t);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("imem_addr", d, addr[d], m_pc[d]);
         check("id_pc", d, idpc[d], m_idpc[d]);
         check("id_instr", d, idin[d], m_instr[d]);
         check("id_valid", d, 32'(idv[d]), 32'(m_v[d]));
         check("id_fault", d, 32'(idf[d]), 32'(m_f[d]));
         check("id_cause", d, 32'(idc[d]), 32'(m_c[d]));
         check("fetch_halted", d, 32'(halt[d]), 32'(m_halt[d]));
      end
   endtask

   function automatic logic [31:0] rand_target();
      case ($urandom_range(0, 6))
         0, 1, 2: return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         3:       return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         4:       return 32'hFF8 + 32'($urandom_range(0, 1)) * 4;
         5:       return 32'h1000;
         default: return 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      rst_n = 0; stall = 0; rv = 0; tgt = 0;
      for (int d = 0; d < 2; d++) model(d, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      step(1, 0, 0, 0);
      // Free run; depth-4 instance runs off its end and faults at 0x10
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      // Redirect beats stall at pc=8
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 1, 32'h40);
      step(0, 0, 0, 0);
      // Stall hold at pc=0xC
      step(0, 0, 1, 32'hC);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Misaligned redirect: bubble, fault report, clear, recover
      step(0, 0, 1, 32'h42);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Last legal word, then out of range
      step(0, 0, 1, 32'hFFC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Stalled pending fault report, then reset while halted and stalled
      step(0, 0, 1, 32'h42);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic r, s, re;
         r  = ($urandom_range(0, 49) == 0);
         re = ($urandom_range(0, 5) == 0);
         s  = ($urandom_range(0, 3) == 0);
         step(r, s, re, rand_target());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
